// File: rtl/sbox_scheduler_if.sv
// Request/result bundle between the S-box scheduler and its two requesters.
// master: round datapath + key schedule side; slave: the scheduler itself.
interface sbox_scheduler_if;
    logic         sb_valid;
    logic         sb_ready;
    logic [127:0] sb_in;
    logic [127:0] sb_out;
    logic         sb_out_valid;
    logic         sb_out_ready;
    logic         sw_valid;
    logic         sw_ready;
    logic [31:0]  sw_in;
    logic [31:0]  sw_out;
    logic         sw_out_valid;
    logic         sw_out_ready;

    modport master (
        output sb_valid, sb_in, sb_out_ready,
        output sw_valid, sw_in, sw_out_ready,
        input  sb_ready, sb_out, sb_out_valid,
        input  sw_ready, sw_out, sw_out_valid
    );

    modport slave (
        input  sb_valid, sb_in, sb_out_ready,
        input  sw_valid, sw_in, sw_out_ready,
        output sb_ready, sb_out, sb_out_valid,
        output sw_ready, sw_out, sw_out_valid
    );
endinterface

// File: rtl/sbox_scheduler.sv
// Shares LANES AES S-boxes between SubBytes (128b) and SubWord (32b).
// Ports: clk, rst_n (sync, active-low), bus (sbox_scheduler_if.slave), busy.
// Option: SBOX_SCHED_RR_EN selects round-robin instead of SubWord-first.
module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] r;
        logic [7:0] s;
        r = '0;
        s = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) r = r ^ s;
            s = xtime(s);
        end
        return r;
    endfunction

    // Multiplicative inverse as v^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] v);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = v;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gmul(r, s);
            s = gmul(s, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign y = affine(ginv(a));
endmodule

module sbox_scheduler #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sbox_scheduler_if.slave    bus,
    output logic               busy
);
    typedef enum logic [2:0] {
        IDLE, SB_RUN, SW_RUN, SB_DONE, SW_DONE
    } state_t;

    localparam int SB_N = 16 / LANES;
    localparam int SW_N = 4 / LANES;

    state_t       state;
    logic [3:0]   cnt;
    logic [127:0] work;
    logic [127:0] nxt;
    logic [127:0] sb_res;
    logic [31:0]  sw_res;
    logic         sb_ov;
    logic         sw_ov;
    logic         sw_pri;
    logic         sb_rdy;
    logic         sw_rdy;
    logic         last;
    int           base;
    logic [7:0]   lane_in  [LANES];
    logic [7:0]   lane_out [LANES];

`ifdef SBOX_SCHED_RR_EN
    // High when SubWord wins a tie, i.e. SubBytes was served last.
    logic sw_first;
    assign sw_pri = sw_first;
`else
    assign sw_pri = 1'b1;
`endif

    assign sw_rdy = (state == IDLE) && bus.sw_valid
                    && (!bus.sb_valid || sw_pri);
    assign sb_rdy = (state == IDLE) && bus.sb_valid
                    && !(bus.sw_valid && sw_pri);

    assign bus.sb_ready     = sb_rdy;
    assign bus.sw_ready     = sw_rdy;
    assign bus.sb_out       = sb_res;
    assign bus.sw_out       = sw_res;
    assign bus.sb_out_valid = sb_ov;
    assign bus.sw_out_valid = sw_ov;

    // SubWord operands sit in the top word so byte i is at the same
    // bit position for both request types.
    assign base = int'(cnt) * LANES;
    assign last = (state == SB_RUN) ? (cnt == 4'(SB_N - 1))
                                    : (cnt == 4'(SW_N - 1));

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_in[j] = work[127 - 8 * (base + j) -: 8];
        end
    end

    always_comb begin
        nxt = work;
        for (int j = 0; j < LANES; j++) begin
            nxt[127 - 8 * (base + j) -: 8] = lane_out[j];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox u_sbox (
            .a (lane_in[g]),
            .y (lane_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            work   <= '0;
            sb_res <= '0;
            sw_res <= '0;
            sb_ov  <= 1'b0;
            sw_ov  <= 1'b0;
            busy   <= 1'b0;
`ifdef SBOX_SCHED_RR_EN
            sw_first <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (sw_rdy) begin
                        work  <= {bus.sw_in, 96'd0};
                        cnt   <= '0;
                        state <= SW_RUN;
                        busy  <= 1'b1;
`ifdef SBOX_SCHED_RR_EN
                        sw_first <= 1'b0;
`endif
                    end else if (sb_rdy) begin
                        work  <= bus.sb_in;
                        cnt   <= '0;
                        state <= SB_RUN;
                        busy  <= 1'b1;
`ifdef SBOX_SCHED_RR_EN
                        sw_first <= 1'b1;
`endif
                    end
                end
                SB_RUN: begin
                    work <= nxt;
                    if (last) begin
                        sb_res <= nxt;
                        sb_ov  <= 1'b1;
                        state  <= SB_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SW_RUN: begin
                    work <= nxt;
                    if (last) begin
                        sw_res <= nxt[127:96];
                        sw_ov  <= 1'b1;
                        state  <= SW_DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SB_DONE: begin
                    if (bus.sb_out_ready) begin
                        sb_ov <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SW_DONE: begin
                    if (bus.sw_out_ready) begin
                        sw_ov <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
